ksa_pipe: RTL and testbench

KSA_PIPE -- requirements
Module: ksa_pipe

---
 rtl/ksa_pkg.sv | 15 +
 rtl/ksa_prefix_level.sv | 19 +
 rtl/ksa_pipe.sv | 130 +++++++++++++
 tb/tb_ksa_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// ksa_pkg: shared sizing helpers and the per-bit generate/propagate record for the Kogge-Stone pipeline
package ksa_pkg;
  typedef struct packed {
    logic g;
    logic p;
  } pg_t;
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic int nstg(input int levels, input int pe);
    return (levels + pe - 1) / pe;
  endfunction
endpackage

// File: rtl/ksa_prefix_level.sv
// ksa_prefix_level: one radix-2 Kogge-Stone combine level at distance DIST
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int BITS = 64,
  parameter int DIST = 1
) (
  input  pg_t [BITS-1:0] x,
  output pg_t [BITS-1:0] y
);
  for (genvar i = 0; i < BITS; i++) begin : g_b
    if (i >= DIST) begin : g_c
      assign y[i].g = x[i].g | (x[i].p & x[i-DIST].g);
      assign y[i].p = x[i].p & x[i-DIST].p;
    end else begin : g_t
      assign y[i] = x[i];
    end
  end
endmodule

// File: rtl/ksa_pipe.sv
// ksa_pipe: pipelined Kogge-Stone add/subtract with valid/ready flow control and in-order tags
// ovf/zero flags are generated only when KSA_PIPE_FLAGS_EN is defined; otherwise tied to 0
module ksa_pipe
  import ksa_pkg::*;
#(
  parameter int BITS       = 64,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  a,
  input  logic [BITS-1:0]  b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  sum,
  output logic             cout,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic             zero
);
  localparam int LEVELS = clog2(BITS);
  localparam int NSTG   = nstg(LEVELS, PIPE_EVERY);
  logic [NSTG:0]     v;
  logic [NSTG+1:0]   ld;
  logic [BITS-1:0]   bx, gf, sum_d, sum_q;
  logic              cout_q;
  logic [NSTG-1:0]   c_q;
  logic [BITS-1:0]   px_q [NSTG];
  logic [TAG_W-1:0]  tag_q [NSTG+1];
  pg_t  [BITS-1:0]   pg0, f0;
  pg_t  [BITS-1:0]   pg_q [NSTG];
  pg_t  [BITS-1:0]   lo [1:LEVELS];
  assign bx = op_sub ? ~b : b;
  assign in_ready  = ld[0] & ~rst;
  assign out_valid = v[NSTG];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_tag   = tag_q[NSTG];
  // a stage may load when empty or when everything downstream of it advances
  always_comb begin
    ld[NSTG+1] = out_ready;
    for (int s = NSTG; s >= 0; s--) ld[s] = ~v[s] | ld[s+1];
  end
  always_comb begin
    for (int i = 0; i < BITS; i++) pg0[i] = '{g: a[i] & bx[i], p: a[i] ^ bx[i]};
  end
  always_comb begin
    f0 = pg_q[0];
    f0[0].g = pg_q[0][0].g | (pg_q[0][0].p & c_q[0]);
  end
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    pg_t [BITS-1:0] x;
    if (k == 1) begin : g_f
      assign x = f0;
    end else if ((k - 1) % PIPE_EVERY == 0) begin : g_r
      assign x = pg_q[(k-1)/PIPE_EVERY];
    end else begin : g_w
      assign x = lo[k-1];
    end
    ksa_prefix_level #(.BITS(BITS), .DIST(1 << (k - 1))) u_lvl (.x(x), .y(lo[k]));
  end
  always_comb begin
    for (int i = 0; i < BITS; i++) gf[i] = lo[LEVELS][i].g;
    sum_d = px_q[NSTG-1] ^ {gf[BITS-2:0], c_q[NSTG-1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= '0;
      c_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      for (int s = 0; s < NSTG; s++) begin
        pg_q[s] <= '0;
        px_q[s] <= '0;
      end
      for (int s = 0; s <= NSTG; s++) tag_q[s] <= '0;
    end else begin
      if (ld[0]) v[0] <= in_valid;
      for (int s = 1; s <= NSTG; s++) if (ld[s]) v[s] <= v[s-1];
      if (ld[0] && in_valid) begin
        pg_q[0]  <= pg0;
        px_q[0]  <= a ^ bx;
        c_q[0]   <= op_sub | cin;
        tag_q[0] <= in_tag;
      end
      for (int s = 1; s < NSTG; s++)
        if (ld[s] && v[s-1]) begin
          pg_q[s]  <= lo[s*PIPE_EVERY];
          px_q[s]  <= px_q[s-1];
          c_q[s]   <= c_q[s-1];
          tag_q[s] <= tag_q[s-1];
        end
      if (ld[NSTG] && v[NSTG-1]) begin
        sum_q       <= sum_d;
        cout_q      <= gf[BITS-1];
        tag_q[NSTG] <= tag_q[NSTG-1];
      end
    end
  end
`ifdef KSA_PIPE_FLAGS_EN
  logic [NSTG-1:0] am_q;
  logic            ovf_q, zero_q;
  // operand signs match exactly when the MSB propagate bit is clear
  always_ff @(posedge clk) begin
    if (rst) begin
      am_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (ld[0] && in_valid) am_q[0] <= a[BITS-1];
      for (int s = 1; s < NSTG; s++) if (ld[s] && v[s-1]) am_q[s] <= am_q[s-1];
      if (ld[NSTG] && v[NSTG-1]) begin
        ovf_q  <= ~px_q[NSTG-1][BITS-1] & (sum_d[BITS-1] ^ am_q[NSTG-1]);
        zero_q <= ~|sum_d;
      end
    end
  end
  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif
endmodule

// File: tb/tb_ksa_pipe.sv
// tb_ksa_pipe: scoreboard bench for ksa_pipe (64-bit/PIPE_EVERY=2 and 8-bit/PIPE_EVERY=1 instances)
module tb_ksa_pipe;
`ifdef KSA_PIPE_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic iv0 = 0, cin0 = 0, sub0 = 0, or0 = 1, ir0, ov0, cout0, ovf0, zero0;
  logic [63:0] a0 = 0, b0 = 0, sum0;
  logic [3:0] tag0 = 0, otag0;
  logic iv1 = 0, cin1 = 0, sub1 = 0, or1 = 1, ir1, ov1, cout1, ovf1, zero1;
  logic [7:0] a1 = 0, b1 = 0, sum1;
  logic [3:0] tag1 = 0, otag1;
  ksa_pipe #(.BITS(64), .PIPE_EVERY(2), .TAG_W(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(cin0), .op_sub(sub0),
    .in_tag(tag0), .out_valid(ov0), .out_ready(or0), .sum(sum0), .cout(cout0), .out_tag(otag0),
    .ovf(ovf0), .zero(zero0));
  ksa_pipe #(.BITS(8), .PIPE_EVERY(1), .TAG_W(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1), .op_sub(sub1),
    .in_tag(tag1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1), .out_tag(otag1),
    .ovf(ovf1), .zero(zero1));
  exp_t q0[$], q1[$];
  int checks = 0, passes = 0, acc0 = 0, out0 = 0, out1 = 0, mode0 = 0, mode1 = 0, last_acc = 0;
  task automatic ck(input bit ok, input string msg);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s", msg);
  endtask
  // reference: plain wide integer arithmetic and textbook signed-overflow rules
  function automatic exp_t model(input int bits, input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic s, input logic [3:0] t);
    exp_t e;
    logic [64:0] full;
    logic [63:0] mask;
    logic am, bm, sm;
    mask = (bits == 64) ? '1 : (64'd1 << bits) - 64'd1;
    a &= mask;
    b &= mask;
    if (s) begin
      full = {1'b0, a} - {1'b0, b};
      e.cout = (a >= b);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {64'd0, c};
      e.cout = full[bits];
    end
    e.sum = full[63:0] & mask;
    am = a[bits-1];
    bm = b[bits-1];
    sm = e.sum[bits-1];
    e.ovf = FL && (s ? (am != bm) : (am == bm)) && (sm != am);
    e.zero = FL && (e.sum == 0);
    e.tag = t;
    return e;
  endfunction
  always @(posedge clk) begin
    #1;
    if (mode0 == 0) or0 = 1;
    else if (mode0 == 1) or0 = ($urandom_range(3) != 0);
    if (mode1 == 0) or1 = 1;
    else if (mode1 == 1) or1 = ($urandom_range(3) != 0);
  end
  exp_t g0, e0, hold0, g1, e1;
  bit held0 = 0;
  always @(negedge clk) begin
    if (rst) held0 = 0;
    else if (ov0) begin
      g0 = '{sum0, cout0, ovf0, zero0, otag0};
      if (held0) ck(g0 == hold0, $sformatf("hold0 got=%h want=%h", g0, hold0));
      if (or0) begin
        if (q0.size() == 0) ck(0, $sformatf("unexpected0 got=%h", g0));
        else begin
          e0 = q0.pop_front();
          ck(g0 == e0, $sformatf("res0 got sum=%h cout=%b ovf=%b zero=%b tag=%0d want sum=%h cout=%b ovf=%b zero=%b tag=%0d",
             g0.sum, g0.cout, g0.ovf, g0.zero, g0.tag, e0.sum, e0.cout, e0.ovf, e0.zero, e0.tag));
        end
        out0++;
        held0 = 0;
      end else begin
        held0 = 1;
        hold0 = g0;
      end
    end else held0 = 0;
  end
  always @(negedge clk) begin
    if (!rst && ov1 && or1) begin
      g1 = '{{56'd0, sum1}, cout1, ovf1, zero1, otag1};
      if (q1.size() == 0) ck(0, $sformatf("unexpected1 got=%h", g1));
      else begin
        e1 = q1.pop_front();
        ck(g1 == e1, $sformatf("res1 got sum=%h cout=%b ovf=%b zero=%b tag=%0d want sum=%h cout=%b ovf=%b zero=%b tag=%0d",
           g1.sum[7:0], g1.cout, g1.ovf, g1.zero, g1.tag, e1.sum[7:0], e1.cout, e1.ovf, e1.zero, e1.tag));
      end
      out1++;
    end
  end
  task automatic send(input int u, input logic [63:0] a, input logic [63:0] b,
                      input logic c, input logic s, input logic [3:0] t);
    int n = 0;
    if (u == 0) begin
      a0 = a; b0 = b; cin0 = c; sub0 = s; tag0 = t; iv0 = 1;
    end else begin
      a1 = a[7:0]; b1 = b[7:0]; cin1 = c; sub1 = s; tag1 = t; iv1 = 1;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(u == 0 ? ir0 : ir1) && n < 200);
    if (!(u == 0 ? ir0 : ir1)) ck(0, $sformatf("accept%0d timeout got in_ready=0 want 1", u));
    else if (u == 0) begin
      q0.push_back(model(64, a, b, c, s, t));
      acc0++;
      last_acc = cyc;
    end else q1.push_back(model(8, a, b, c, s, t));
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) ck(0, $sformatf("drain timeout got pending=%0d/%0d want 0", q0.size(), q1.size()));
  endtask
  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction
  initial begin
    int n, ob, ab;
    bit seen;
    logic [63:0] x, y;
    logic [7:0] cn [4];
    cn[0] = 8'h00; cn[1] = 8'h7f; cn[2] = 8'h80; cn[3] = 8'hff;
    repeat (3) @(posedge clk);
    #1;
    ck(ir0 == 0 && ir1 == 0, $sformatf("rst_in_ready got=%b%b want 00", ir0, ir1));
    ck({ov0, cout0, ovf0, zero0, otag0} == 0 && sum0 == 0,
       $sformatf("reset0 got valid=%b sum=%h cout=%b tag=%0d want all 0", ov0, sum0, cout0, otag0));
    ck({ov1, cout1, ovf1, zero1, otag1} == 0 && sum1 == 0,
       $sformatf("reset1 got valid=%b sum=%h want all 0", ov1, sum1));
    rst = 0;
    @(posedge clk);
    #1;
    send(0, '1, 64'd1, 0, 0, 4'd1);
    iv0 = 0;
    n = 0;
    while (!ov0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ck(ov0 && (cyc - last_acc) == 4, $sformatf("latency got=%0d valid=%b want 4", cyc - last_acc, ov0));
    ck(sum0 == 0 && cout0 == 1 && zero0 == FL && ovf0 == 0,
       $sformatf("ones_plus_one got sum=%h cout=%b zero=%b ovf=%b want 0 1 %b 0", sum0, cout0, zero0, ovf0, FL));
    @(posedge clk);
    #1;
    send(0, 64'd5, 64'd7, 1, 1, 4'd2);
    send(0, 64'd7, 64'd5, 0, 1, 4'd3);
    send(0, 64'h7fff_ffff_ffff_ffff, 64'd1, 0, 0, 4'd4);
    send(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 0, 4'd5);
    iv0 = 0;
    drain();
    mode0 = 2;
    or0 = 1;
    ob = out0;
    ab = acc0;
    seen = 0;
    fork
      for (int i = 0; i < 10; i++) send(0, r64(), r64(), 1'($urandom_range(1)), 1'($urandom_range(1)), 4'(i));
      for (int c = 0; c < 12; c++) begin
        or0 = !(c >= 2 && c <= 9);
        @(posedge clk);
        #1;
      end
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (!ir0 && !seen) begin
          seen = 1;
          ck((acc0 - ab) - (out0 - ob) == 4, $sformatf("bp_full got held=%0d want 4", (acc0 - ab) - (out0 - ob)));
        end
      end
    join
    iv0 = 0;
    mode0 = 0;
    ck(seen, "bp_stall got in_ready never low want low");
    drain();
    ck(out0 - ob == 10, $sformatf("bp_count got=%0d want 10", out0 - ob));
    mode0 = 2;
    or0 = 0;
    for (int i = 0; i < 3; i++) send(0, r64(), r64(), 0, 0, 4'(i));
    iv0 = 0;
    rst = 1;
    @(posedge clk);
    #1;
    q0.delete();
    ck(ov0 == 0, $sformatf("flush got out_valid=%b want 0", ov0));
    rst = 0;
    mode0 = 0;
    ob = out0;
    send(0, 64'd100, 64'd23, 1, 0, 4'd9);
    send(0, 64'd50, 64'd60, 0, 1, 4'd10);
    iv0 = 0;
    drain();
    repeat (8) @(posedge clk);
    #1;
    ck(out0 - ob == 2, $sformatf("post_reset_count got=%0d want 2", out0 - ob));
    mode0 = 1;
    for (int i = 0; i < 300; i++) begin
      x = r64();
      case ($urandom_range(3))
        0: y = -x;
        1: y = x;
        default: y = r64();
      endcase
      send(0, x, y, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom));
    end
    iv0 = 0;
    mode1 = 1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 3; k++)
          send(1, {56'd0, cn[i]}, {56'd0, cn[j]}, k == 1, k == 2, 4'(i * 4 + j));
    for (int i = 0; i < 2500; i++)
      send(1, 64'($urandom_range(255)), 64'($urandom_range(255)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 4'($urandom));
    iv1 = 0;
    drain();
    mode0 = 0;
    mode1 = 0;
    ck(q0.size() == 0, $sformatf("left0 got=%0d want 0", q0.size()));
    ck(q1.size() == 0, $sformatf("left1 got=%0d want 0", q1.size()));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
